// File: rtl/vc_serializer_pkg.sv
// Shared definitions for the register serializer: FSM state encoding and
// chunk-counter sizing.
package vc_serializer_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;

  typedef enum logic {
    IDLE = STATE_IDLE,
    SEND = STATE_SEND
  } state_t;

  // Counter must hold 0..n-1, but never collapse to zero width when n==1.
  function automatic int count_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_reg_serializer_dpath.sv
// Loadable right-shift register and chunk counter for vc_reg_serializer.
// Priority: clear over load over shift.
module vc_reg_serializer_dpath
  import vc_serializer_pkg::*;
#(
  parameter int p_nbits       = 32,
  parameter int p_chunk_nbits = 8,
  localparam int N            = p_nbits / p_chunk_nbits,
  localparam int CW           = count_w(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [p_nbits-1:0]       in_msg,
  output logic [p_chunk_nbits-1:0] chunk,
  output logic [CW-1:0]            count
);

  logic [p_nbits-1:0] shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= in_msg;
      count <= '0;
    end else if (shift) begin
      shreg <= shreg >> p_chunk_nbits;
      count <= count + CW'(1);
    end
  end

  assign chunk = shreg[p_chunk_nbits-1:0];

endmodule

// File: rtl/vc_reg_serializer.sv
// Parallel-in, serial-out register reader: one p_nbits word in, LSB chunk first out.
// Optional VC_SERIALIZER_DOMAIN_FLUSH_EN aborts an in-flight word when sd changes.
module vc_reg_serializer
  import vc_serializer_pkg::*;
#(
  parameter int p_nbits       = 32,
  parameter int p_chunk_nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sd,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [p_nbits-1:0]       in_msg,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [p_chunk_nbits-1:0] out_msg,
  output logic                     out_last
);

  localparam int N  = p_nbits / p_chunk_nbits;
  localparam int CW = count_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic          ready_q;
  logic          load, shift, clear, flush;
  logic [CW-1:0] count;

  // Holds in_rdy low for the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

`ifdef VC_SERIALIZER_DOMAIN_FLUSH_EN
  logic sd_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    sd_q <= 1'b0;
    else if (load) sd_q <= sd;
  end
  assign flush = (sd != sd_q);
`else
  logic unused_sd;
  assign unused_sd = sd;
  assign flush     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = ready_q;
        if (in_val && ready_q) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_val  = 1'b1;
        out_last = (count == LAST);
        if (flush) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (out_rdy) begin
          if (out_last) begin
            clear     = 1'b1;
            state_nxt = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  vc_reg_serializer_dpath #(
    .p_nbits      (p_nbits),
    .p_chunk_nbits(p_chunk_nbits)
  ) u_dpath (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .clear (clear),
    .in_msg(in_msg),
    .chunk (out_msg),
    .count (count)
  );

  a_ctl_not_x: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown(in_val) && !$isunknown(out_rdy));

endmodule

// File: tb/tb_vc_reg_serializer.sv
// Bench for vc_reg_serializer: 32/8 instance driven with directed and random
// words against a byte-slicing reference, plus an 8/8 single-chunk instance.
module tb_vc_reg_serializer;

  logic        clk = 1'b0;
  logic        reset, sd;
  logic        in_val, in_rdy, out_val, out_rdy, out_last;
  logic [31:0] in_msg;
  logic [7:0]  out_msg;
  logic        s_in_val, s_in_rdy, s_out_val, s_out_rdy, s_out_last;
  logic [7:0]  s_in_msg, s_out_msg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vc_reg_serializer #(.p_nbits(32), .p_chunk_nbits(8)) dut (
    .clk(clk), .reset(reset), .sd(sd),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_last(out_last)
  );

  vc_reg_serializer #(.p_nbits(8), .p_chunk_nbits(8)) dut1 (
    .clk(clk), .reset(reset), .sd(sd),
    .in_val(s_in_val), .in_rdy(s_in_rdy), .in_msg(s_in_msg),
    .out_val(s_out_val), .out_rdy(s_out_rdy), .out_msg(s_out_msg), .out_last(s_out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: chunk i of a word is simply byte i.
  function automatic logic [7:0] ref_chunk(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word and check every presented chunk. stall_idx forces three
  // stall cycles on that chunk; hold keeps a next word pending on in_val.
  task automatic run_word(input logic [31:0] w, input int stall_pct, input int stall_idx,
                          input logic hold, input logic [31:0] nxt);
    int i = 0;
    int guard = 0;
    int stalls = 0;
    chk("pre_in_rdy", 32'(in_rdy), 1);
    in_val = 1'b1;
    in_msg = w;
    tick();
    in_val = hold;
    in_msg = hold ? nxt : 32'h0;
    while (i < 4) begin
      chk("out_val", 32'(out_val), 1);
      chk("in_rdy_busy", 32'(in_rdy), 0);
      chk("out_msg", 32'(out_msg), 32'(ref_chunk(w, i)));
      chk("out_last", 32'(out_last), 32'(i == 3));
      if (i == stall_idx && stalls < 3) begin
        out_rdy = 1'b0;
        stalls++;
      end else begin
        out_rdy = ($urandom_range(99) >= stall_pct);
      end
      tick();
      if (out_rdy) i++;
      guard++;
      if (guard > 100) begin
        chk("word_timeout", 32'(guard), 0);
        break;
      end
    end
    chk("done_out_val", 32'(out_val), 0);
    chk("done_in_rdy", 32'(in_rdy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; sd = 1'b0;
    in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
    s_in_val = 1'b0; s_in_msg = '0; s_out_rdy = 1'b0;
    #1;
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_out_last", 32'(out_last), 0);
    tick();
    chk("rst_hold_in_rdy", 32'(in_rdy), 0);
    #4 reset = 1'b1;
    tick();
    chk("post_rst_in_rdy", 32'(in_rdy), 1);
    chk("post_rst_s_in_rdy", 32'(s_in_rdy), 1);

    // Plain word at full rate, then a three-cycle stall on BE.
    run_word(32'hDEADBEEF, 0, -1, 1'b0, 32'h0);
    run_word(32'hDEADBEEF, 0, 1, 1'b0, 32'h0);

    // Next word pending during SEND must wait for IDLE.
    run_word(32'hDEADBEEF, 0, -1, 1'b1, 32'h01234567);
    run_word(32'h01234567, 0, -1, 1'b0, 32'h0);

    for (int k = 0; k < 20; k++) run_word($urandom(), 35, -1, 1'b0, 32'h0);

    // Async reset mid-word.
    out_rdy = 1'b1;
    in_val = 1'b1; in_msg = 32'hDEADBEEF;
    tick();
    in_val = 1'b0;
    chk("rw_c0", 32'(out_msg), 32'hEF);
    tick();
    chk("rw_c1", 32'(out_msg), 32'hBE);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_out_val", 32'(out_val), 0);
    chk("arst_in_rdy", 32'(in_rdy), 0);
    chk("arst_out_last", 32'(out_last), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("rel_in_rdy", 32'(in_rdy), 1);
    for (int k = 0; k < 3; k++) begin
      chk("no_residual", 32'(out_val), 0);
      tick();
    end

    // Domain change after the first chunk.
    sd = 1'b0; out_rdy = 1'b1;
    in_val = 1'b1; in_msg = 32'hDEADBEEF;
    tick();
    in_val = 1'b0;
    chk("fl_c0", 32'(out_msg), 32'hEF);
    sd = 1'b1;
    tick();
`ifdef VC_SERIALIZER_DOMAIN_FLUSH_EN
    chk("fl_out_val", 32'(out_val), 0);
    chk("fl_in_rdy", 32'(in_rdy), 1);
`else
    for (int i = 1; i < 4; i++) begin
      chk("nofl_msg", 32'(out_msg), 32'(ref_chunk(32'hDEADBEEF, i)));
      chk("nofl_last", 32'(out_last), 32'(i == 3));
      tick();
    end
    chk("nofl_done", 32'(out_val), 0);
`endif
    // Domain change while stalled.
    out_rdy = 1'b0;
    in_val = 1'b1; in_msg = 32'hCAFEF00D;
    tick();
    in_val = 1'b0;
    sd = 1'b0;
    tick();
`ifdef VC_SERIALIZER_DOMAIN_FLUSH_EN
    chk("fl_stall_val", 32'(out_val), 0);
`else
    chk("nofl_stall_msg", 32'(out_msg), 32'h0D);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("nofl2_msg", 32'(out_msg), 32'(ref_chunk(32'hCAFEF00D, i)));
      tick();
    end
    chk("nofl2_done", 32'(out_val), 0);
`endif

    // Single-chunk instance: out_last whenever valid.
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = (k == 0) ? 8'h5A : 8'($urandom());
      chk("s_pre_rdy", 32'(s_in_rdy), 1);
      s_in_val = 1'b1; s_in_msg = b; s_out_rdy = 1'b0;
      tick();
      s_in_val = 1'b0;
      chk("s_val", 32'(s_out_val), 1);
      chk("s_msg", 32'(s_out_msg), 32'(b));
      chk("s_last", 32'(s_out_last), 1);
      chk("s_busy", 32'(s_in_rdy), 0);
      tick();
      chk("s_hold_msg", 32'(s_out_msg), 32'(b));
      s_out_rdy = 1'b1;
      tick();
      chk("s_done_val", 32'(s_out_val), 0);
      chk("s_done_rdy", 32'(s_in_rdy), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
